// File: rtl/sprite_blitter.sv
`timescale 1ns/1ps
// Sprite blitter: streams a SPR_W x SPR_H sprite from a synchronous ROM into the VGA pixel port.
// Optional colour keying is enabled with the macro SPRITE_BLITTER_TRANSPARENCY_EN.
//
// state | meaning
// IDLE  | waiting for start; anchor and erase latched on accept
// RUN   | one ROM address per cycle, row-major
// FLUSH | draining the ROM and pixel pipeline stages
// DONE  | one-cycle done pulse, then IDLE
module sprite_blitter #(
    parameter int         SPR_W      = 27,
    parameter int         SPR_H      = 48,
    parameter int         ADDR_W     = 11,
    parameter int         SCREEN_W   = 160,
    parameter int         SCREEN_H   = 120,
    parameter logic [2:0] BG_COLOUR  = 3'b000,
    parameter logic [2:0] KEY_COLOUR = 3'b000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              erase,
    input  logic [7:0]        x0,
    input  logic [7:0]        y0,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [7:0]        vga_x,
    output logic [7:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot
);

    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ax_q, ax_d;
    logic [7:0]        ay_q, ay_d;
    logic              erase_q, erase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              s1_valid_q, s1_valid_d;
    logic [COL_W-1:0]  s1_col_q, s1_col_d;
    logic [ROW_W-1:0]  s1_row_q, s1_row_d;
    logic              out_valid_q, out_valid_d;

    logic [7:0]        vga_x_q, vga_x_d;
    logic [7:0]        vga_y_q, vga_y_d;
    logic [2:0]        vga_colour_q, vga_colour_d;
    logic              vga_plot_q, vga_plot_d;

    logic [8:0]        x_sum;
    logic [8:0]        y_sum;
    logic              in_bounds;
    logic              transparent;

    // Sums are 9 bits so an anchor near the right/bottom edge clips instead of wrapping.
    always_comb begin
        x_sum     = {1'b0, ax_q} + 9'(s1_col_q);
        y_sum     = {1'b0, ay_q} + 9'(s1_row_q);
        in_bounds = (x_sum < 9'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
        transparent = !erase_q && (rom_data == KEY_COLOUR);
`else
        transparent = 1'b0 && (rom_data == KEY_COLOUR);
`endif
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        ax_d         = ax_q;
        ay_d         = ay_q;
        erase_d      = erase_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        s1_valid_d   = 1'b0;
        s1_col_d     = s1_col_q;
        s1_row_d     = s1_row_q;
        out_valid_d  = s1_valid_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ax_d    = x0;
                    ay_d    = y0;
                    erase_d = erase;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s1_valid_d = 1'b1;
                s1_col_d   = col_q;
                s1_row_d   = row_q;
                if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                    state_d = S_FLUSH;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (!s1_valid_q && !out_valid_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // rom_data here belongs to the address held in the s1 stage.
        if (s1_valid_q) begin
            vga_x_d      = x_sum[7:0];
            vga_y_d      = y_sum[7:0];
            vga_colour_d = erase_q ? BG_COLOUR : rom_data;
            vga_plot_d   = in_bounds && !transparent;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
            erase_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
            out_valid_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            ax_q         <= ax_d;
            ay_q         <= ay_d;
            erase_q      <= erase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            s1_valid_q   <= s1_valid_d;
            s1_col_q     <= s1_col_d;
            s1_row_q     <= s1_row_d;
            out_valid_q  <= out_valid_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rom_addr   = addr_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
`timescale 1ns/1ps
// Testbench for sprite_blitter: randomized draws checked against a pixel-list reference model.
module tb_sprite_blitter;

    localparam int SPR_W = 27;
    localparam int SPR_H = 48;
    localparam int N     = SPR_W * SPR_H;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        erase;
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic        busy;
    logic        done;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data = 3'd0;
    logic [7:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    sprite_blitter dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .erase      (erase),
        .x0         (x0),
        .y0         (y0),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #10 clock = ~clock;

    logic [2:0] rom_mem [0:2047];
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } pix_t;

    pix_t cap_q[$];
    pix_t exp_q[$];
    int   addr_q[$];
    pix_t mon_p;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_cnt = 0;
    logic busy_at_done = 1'b0;

    // Monitor samples on the falling edge, half a cycle away from DUT updates.
    always @(negedge clock) begin
        if (vga_plot) begin
            mon_p.cyc = cyc;
            mon_p.x   = int'(vga_x);
            mon_p.y   = int'(vga_y);
            mon_p.c   = int'(vga_colour);
            cap_q.push_back(mon_p);
        end
        if (busy) begin
            busy_cnt <= busy_cnt + 1;
            addr_q.push_back(int'(rom_addr));
        end
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            busy_at_done <= busy;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int s_cyc;
    int done_base;
    int busy_base;
    bit timed_out;

    // Reference: every sprite pixel p maps to one slot, plotted 2+p edges after start.
    task automatic build_model(input int ax, input int ay, input bit er, input int s);
        pix_t e;
        exp_q.delete();
        for (int p = 0; p < N; p++) begin
            int  x;
            int  y;
            int  c;
            bit  vis;
            x   = ax + (p % SPR_W);
            y   = ay + (p / SPR_W);
            c   = er ? 0 : int'(rom_mem[p]);
            vis = (x < SCR_W) && (y < SCR_H);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
            if (!er && c == 0) vis = 1'b0;
`endif
            if (vis) begin
                e.cyc = s + 2 + p;
                e.x   = x;
                e.y   = y;
                e.c   = c;
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (cap_q[i].cyc != exp_q[i].cyc || cap_q[i].x != exp_q[i].x ||
                cap_q[i].y != exp_q[i].y || cap_q[i].c != exp_q[i].c)
                return i;
        end
        if (cap_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic fill_rom_random();
        for (int i = 0; i < 2048; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic do_draw(input int ax, input int ay, input bit er, input bit disturb, input bit settle);
        cap_q.delete();
        addr_q.delete();
        @(negedge clock);
        x0        = 8'(ax);
        y0        = 8'(ay);
        erase     = er;
        start     = 1'b1;
        s_cyc     = cyc + 1;
        done_base = done_cnt;
        busy_base = busy_cnt;
        @(negedge clock);
        start = 1'b0;
        x0    = 8'($urandom);
        y0    = 8'($urandom);
        erase = 1'($urandom);
        if (disturb) begin
            repeat (100) @(negedge clock);
            start = 1'b1;
            x0    = 8'd50;
            repeat (5) @(negedge clock);
            start = 1'b0;
        end
        timed_out = 1'b1;
        for (int i = 0; i < N + 40; i++) begin
            @(posedge clock);
            if (done_cnt != done_base) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (settle) repeat (6) @(posedge clock);
        build_model(ax, ay, er, s_cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        erase = 1'b0;
        x0    = '0;
        y0    = '0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vga_plot !== 1'b0)
            $display("FAIL reset_ctrl: busy=%b done=%b plot=%b, required 0 0 0", busy, done, vga_plot);
        else n_pass++;
        n_checks++;
        if (rom_addr !== 11'd0)
            $display("FAIL reset_addr: rom_addr=%0d, required 0", rom_addr);
        else n_pass++;
        n_checks++;
        if (vga_x !== 8'd0 || vga_y !== 8'd0 || vga_colour !== 3'd0)
            $display("FAIL reset_pix: x=%0d y=%0d c=%0d, required 0 0 0", vga_x, vga_y, vga_colour);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        int d;
        for (int i = 0; i < 2048; i++) rom_mem[i] = 3'(i % 8);
        do_draw(10, 20, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (timed_out) $display("FAIL basic_timeout: no done within %0d cycles", N + 40);
        else n_pass++;
        n_checks++;
        d = first_diff();
        if (d >= 0) $display("FAIL basic_pixels: first difference at slot %0d, got %0d plots, required %0d", d, cap_q.size(), exp_q.size());
        else n_pass++;
`ifndef SPRITE_BLITTER_TRANSPARENCY_EN
        n_checks++;
        if (cap_q.size() != N) $display("FAIL basic_count: got %0d plots, required %0d", cap_q.size(), N);
        else n_pass++;
        n_checks++;
        if (cap_q.size() == 0 || cap_q[0].cyc != s_cyc + 2 || cap_q[0].x != 10 || cap_q[0].y != 20 || cap_q[0].c != 0)
            $display("FAIL basic_first: first plot wrong or missing, required (10,20) colour 0 at edge %0d", s_cyc + 2);
        else n_pass++;
        n_checks++;
        if (cap_q.size() == 0 || cap_q[cap_q.size()-1].x != 36 || cap_q[cap_q.size()-1].y != 67 || cap_q[cap_q.size()-1].c != 7)
            $display("FAIL basic_last: last plot wrong or missing, required (36,67) colour 7");
        else n_pass++;
`endif
        n_checks++;
        if (done_cnt - done_base != 1 || done_cyc != s_cyc + N + 3)
            $display("FAIL basic_done: %0d pulses at offset %0d, required 1 at %0d", done_cnt - done_base, done_cyc - s_cyc, N + 3);
        else n_pass++;
        n_checks++;
        if (busy_at_done !== 1'b0 || busy_cnt - busy_base != N + 3)
            $display("FAIL basic_busy: busy_at_done=%b busy_cycles=%0d, required 0 and %0d", busy_at_done, busy_cnt - busy_base, N + 3);
        else n_pass++;
    endtask

    task automatic test_erase();
        int  d;
        bit  ok;
        fill_rom_random();
        do_draw(0, 0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        d = first_diff();
        if (d >= 0 || cap_q.size() != N) $display("FAIL erase_pixels: first difference at slot %0d, got %0d plots, required %0d", d, cap_q.size(), N);
        else n_pass++;
        ok = (addr_q.size() == N + 3);
        for (int k = 0; k < addr_q.size() && ok; k++)
            if (addr_q[k] != ((k < N) ? k : N - 1)) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL erase_addr_sweep: %0d busy samples, required %0d with rom_addr 0..%0d", addr_q.size(), N + 3, N - 1);
        else n_pass++;
    endtask

    task automatic test_clip();
        int d;
        int xmax;
        fill_rom_random();
        do_draw(150, 100, 1'b0, 1'b0, 1'b1);
        n_checks++;
        d = first_diff();
        if (d >= 0) $display("FAIL clip_pixels: first difference at slot %0d, got %0d plots, required %0d", d, cap_q.size(), exp_q.size());
        else n_pass++;
`ifndef SPRITE_BLITTER_TRANSPARENCY_EN
        n_checks++;
        if (cap_q.size() != 200) $display("FAIL clip_count: got %0d plots, required 200", cap_q.size());
        else n_pass++;
`endif
        xmax = 0;
        foreach (cap_q[i]) if (cap_q[i].x > xmax) xmax = cap_q[i].x;
        n_checks++;
        if (xmax >= SCR_W) $display("FAIL clip_xmax: max plotted x=%0d, required < %0d", xmax, SCR_W);
        else n_pass++;
        n_checks++;
        if (timed_out || done_cyc != s_cyc + N + 3) $display("FAIL clip_done: done offset %0d, required %0d", done_cyc - s_cyc, N + 3);
        else n_pass++;
    endtask

    task automatic test_offscreen();
        fill_rom_random();
        do_draw(200, $urandom_range(0, 100), 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (cap_q.size() != 0) $display("FAIL offscreen_count: got %0d plots, required 0", cap_q.size());
        else n_pass++;
        n_checks++;
        if (timed_out || done_cnt - done_base != 1 || done_cyc != s_cyc + N + 3)
            $display("FAIL offscreen_done: %0d pulses at offset %0d, required 1 at %0d", done_cnt - done_base, done_cyc - s_cyc, N + 3);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d;
        fill_rom_random();
        do_draw(30, 40, 1'b0, 1'b1, 1'b0);
        n_checks++;
        d = first_diff();
        if (d >= 0) $display("FAIL busy_start_pixels: first difference at slot %0d, got %0d plots, required %0d", d, cap_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (timed_out || done_cyc != s_cyc + N + 3) $display("FAIL busy_start_done: done offset %0d, required %0d", done_cyc - s_cyc, N + 3);
        else n_pass++;
        do_draw(5, 6, 1'b0, 1'b0, 1'b1);
        n_checks++;
        d = first_diff();
        if (timed_out || d >= 0) $display("FAIL b2b_pixels: first difference at slot %0d, got %0d plots, required %0d", d, cap_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 3; it++) begin
            fill_rom_random();
            do_draw($urandom_range(0, 199), $urandom_range(0, 139), 1'($urandom), 1'b0, 1'b1);
            n_checks++;
            d = first_diff();
            if (timed_out || d >= 0 || done_cyc != s_cyc + N + 3)
                $display("FAIL random_%0d: diff slot %0d, plots %0d required %0d, done offset %0d required %0d", it, d, cap_q.size(), exp_q.size(), done_cyc - s_cyc, N + 3);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int  d;
        int  n_at_reset;
        int  dn;
        bit  reached;
        fill_rom_random();
        cap_q.delete();
        @(negedge clock);
        x0    = 8'd12;
        y0    = 8'd3;
        erase = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(posedge clock);
            if (cap_q.size() >= 500) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!reached) $display("FAIL midreset_progress: only %0d plots before bound, required 500", cap_q.size());
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset_async: plot=%b busy=%b done=%b, required 0 0 0", vga_plot, busy, done);
        else n_pass++;
        n_at_reset = cap_q.size();
        dn = done_cnt;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        n_checks++;
        if (cap_q.size() != n_at_reset || done_cnt != dn || busy !== 1'b0)
            $display("FAIL midreset_quiet: %0d extra plots, %0d extra done, busy=%b, required 0 0 0", cap_q.size() - n_at_reset, done_cnt - dn, busy);
        else n_pass++;
        do_draw(12, 3, 1'b0, 1'b0, 1'b1);
        n_checks++;
        d = first_diff();
        if (timed_out || d >= 0) $display("FAIL midreset_redraw: first difference at slot %0d, got %0d plots, required %0d", d, cap_q.size(), exp_q.size());
        else n_pass++;
    endtask

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    task automatic test_transparency();
        for (int i = 0; i < 2048; i++) rom_mem[i] = 3'($urandom_range(1, 7));
        for (int i = 0; i < 1200; i += 4) rom_mem[i] = 3'd0;
        do_draw(0, 0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (cap_q.size() != N - 300 || first_diff() >= 0) $display("FAIL transp_count: got %0d plots, required %0d", cap_q.size(), N - 300);
        else n_pass++;
        do_draw(0, 0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (cap_q.size() != N || first_diff() >= 0) $display("FAIL transp_erase: got %0d plots, required %0d", cap_q.size(), N);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 3'd0;
        test_reset();
        test_basic();
        test_erase();
        test_clip();
        test_offscreen();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
        test_transparency();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Walks a rectangular sprite stored in a synchronous sprite ROM and streams (x, y, colour, plot) writes into the VGA adapter's pixel port.
- Sits between the game control FSM/sprite ROM upstream and vga_adapter downstream. Replaces the ad-hoc x/y counter datapath.
- One request draws (or erases) one sprite at an anchor (x0, y0), clipping pixels that fall off-screen.

Parameters:
- SPR_W, 27, sprite width in pixels
- SPR_H, 48, sprite height in pixels
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- SCREEN_W, 160, visible width; columns >= SCREEN_W are clipped
- SCREEN_H, 120, visible height; rows >= SCREEN_H are clipped
- BG_COLOUR, 3'b000, colour written in erase mode
- KEY_COLOUR, 3'b000, transparent colour (used only with the optional feature)

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse/level; sampled only in IDLE
- erase  in  1  sampled with start; 1 = paint BG_COLOUR instead of ROM data
- x0  in  8  anchor column (top-left), sampled with start
- y0  in  8  anchor row (top-left), sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel slot
- rom_addr  out  ADDR_W  sprite ROM address, row-major (row*SPR_W + col)
- rom_data  in  3  ROM pixel; valid one cycle after rom_addr
- vga_x  out  8  pixel column to vga_adapter
- vga_y  out  8  pixel row to vga_adapter
- vga_colour  out  3  pixel colour to vga_adapter
- vga_plot  out  1  write strobe to vga_adapter

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, vga_plot=0, rom_addr=0, vga_x=0, vga_y=0, vga_colour=0; counters cleared. Reset mid-draw abandons the sprite; no further plots.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on the edge where start=1, latch x0, y0, erase; col=0, row=0; rom_addr=0; go to RUN; busy=1. start=0 leaves it in IDLE.
- RUN: each cycle advance col (wrap to 0 at SPR_W-1 and increment row) and drive rom_addr=row*SPR_W+col. Maintain rom_addr incrementally; no multiplier. After issuing the address for (SPR_W-1, SPR_H-1), go to FLUSH.
- Pixel pipeline: the address issued at edge n gives its pixel output registered at edge n+1.
  - vga_x = x0+col_d, vga_y = y0+row_d, where col_d/row_d are the 1-cycle delayed counters.
  - vga_colour = erase_l ? BG_COLOUR : rom_data.
- FLUSH: emits the final pipelined pixel, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0 on the same edge, then IDLE. A new start is accepted no earlier than the cycle after done.
- Throughput and latency: one pixel slot per clock. First vga_plot appears 2 edges after the start edge. done asserts SPR_W*SPR_H+1 edges after the first plot edge.
- Clipping: sums are computed 9 bits wide; no wrap-around. A slot with x0+col >= SCREEN_W or y0+row >= SCREEN_H gets vga_plot=0. The slot is still consumed, so timing is independent of position.
- Anchor fully off-screen (x0 >= SCREEN_W): full-length run with zero plots; done still pulses.
- start while busy: ignored, not queued. erase/x0/y0 changes while busy: no effect.
- vga_plot is 0 in IDLE, DONE and the first RUN cycle.

Optional Feature:
- Macro: SPRITE_BLITTER_TRANSPARENCY_EN.
- Defined: when erase_l=0 and rom_data==KEY_COLOUR, vga_plot=0 for that slot, leaving the background visible. Slot timing is unchanged. Erase mode is unaffected; all pixels are written with BG_COLOUR.
- Undefined: every in-bounds slot plots; KEY_COLOUR is unused.

Test Plan:
- Reset then start=1 with x0=10, y0=20, erase=0, ROM pattern addr[2:0] -> first plot at (10,20) colour=ROM[0] two edges after start. Exactly 1296 plots occur. Last plot at (36,67) colour=ROM[1295]. done pulses once; busy low with done.
- Erase: x0=0, y0=0, erase=1 -> 1296 plots, all colour=BG_COLOUR; rom_addr still sweeps 0..1295.
- Clipping: x0=150, y0=100 -> plots only where col<=9 and row<=19 (200 plots). No vga_x >= 160. done timing identical to the first scenario.
- Off-screen: x0=200 -> zero plots; done still pulses after the same cycle count.
- start held high for 5 cycles during RUN, x0 changed to 50 -> no restart, all plots use the original x0. A start in the cycle after done is accepted.
- Assert reset at pixel 500 -> vga_plot, busy, done drop to 0 asynchronously. After release, a new start draws the full 1296 pixels from (col 0, row 0).
- With SPRITE_BLITTER_TRANSPARENCY_EN, KEY_COLOUR=0, ROM containing 300 zero pixels -> 996 plots. With erase=1 -> 1296 plots.
